// File: rtl/dpram_gen.sv
`default_nettype none
// ============================================================================
// Module   : dpram_gen
// Purpose  : Single-clock true dual-port RAM with byte enables, per-port write
//            modes, optional output register and a power-up clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_gen #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 10,
  parameter int                 OUT_REG  = 0,
  parameter string              WMODE_A  = "WRITE_FIRST",
  parameter string              WMODE_B  = "WRITE_FIRST",
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     aa,
  input  logic [DATA_W-1:0]     ai,
  input  logic                  acs,
  input  logic                  awe,
  input  logic [DATA_W/8-1:0]   abe,
  output logic [DATA_W-1:0]     ao,
  output logic                  aov,
  input  logic [ADDR_W-1:0]     ba,
  input  logic [DATA_W-1:0]     bi,
  input  logic                  bcs,
  input  logic                  bwe,
  input  logic [DATA_W/8-1:0]   bbe,
  output logic [DATA_W-1:0]     bo,
  output logic                  bov
);

  localparam int               c_nb    = DATA_W / 8;
  localparam int               c_depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last = '1;
  localparam logic [1:0]       c_wf    = 2'd0;
  localparam logic [1:0]       c_rf    = 2'd1;
  localparam logic [1:0]       c_nc    = 2'd2;
  localparam logic [1:0] c_mode_a = (WMODE_A == "READ_FIRST") ? c_rf :
                                    (WMODE_A == "NO_CHANGE")  ? c_nc : c_wf;
  localparam logic [1:0] c_mode_b = (WMODE_B == "READ_FIRST") ? c_rf :
                                    (WMODE_B == "NO_CHANGE")  ? c_nc : c_wf;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [c_depth];

  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_din  [2];
  logic [DATA_W-1:0] w_old  [2];
  logic [DATA_W-1:0] w_out  [2];
  logic [c_nb-1:0]   w_be   [2];
  logic [c_nb-1:0]   w_wbe  [2];
  logic              w_cs   [2];
  logic              w_we   [2];
  logic              w_vld  [2];

  assign w_addr[0] = aa;  assign w_addr[1] = ba;
  assign w_din[0]  = ai;  assign w_din[1]  = bi;
  assign w_be[0]   = abe; assign w_be[1]   = bbe;
  assign w_cs[0]   = acs; assign w_cs[1]   = bcs;
  assign w_we[0]   = awe; assign w_we[1]   = bwe;
  assign ao  = w_out[0];
  assign aov = w_vld[0];
  assign bo  = w_out[1];
  assign bov = w_vld[1];
  assign busy = (r_state == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_last) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: begin
        if (clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Port A lanes are written after port B so A wins on a shared byte.
  always_ff @(posedge clk) begin
    if (busy) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else begin
      for (int i = 0; i < c_nb; i++) begin
        if (w_wbe[1][i]) r_mem[w_addr[1]][8*i +: 8] <= w_din[1][8*i +: 8];
        if (w_wbe[0][i]) r_mem[w_addr[0]][8*i +: 8] <= w_din[0][8*i +: 8];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic [1:0] c_mode = (p == 0) ? c_mode_a : c_mode_b;

    logic              w_acc;
    logic [DATA_W-1:0] w_merge;
    logic              r_v0, r_u0;
    logic [DATA_W-1:0] r_d0;
    logic              w_v1, w_u1;
    logic [DATA_W-1:0] w_d1;
    logic              r_vo;
    logic [DATA_W-1:0] r_do;

    assign w_acc    = w_cs[p] & ~busy;
    assign w_wbe[p] = {c_nb{w_acc & w_we[p]}} & w_be[p];
    // Combinational read yields the pre-write word, giving read-old on collisions.
    assign w_old[p] = r_mem[w_addr[p]];

    always_comb begin
      w_merge = w_old[p];
      for (int i = 0; i < c_nb; i++) begin
        if (w_be[p][i]) w_merge[8*i +: 8] = w_din[p][8*i +: 8];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v0 <= 1'b0;
        r_u0 <= 1'b0;
        r_d0 <= '0;
      end else begin
        r_v0 <= w_acc;
        r_u0 <= w_acc & ~(w_we[p] & (c_mode == c_nc));
        if (w_acc) r_d0 <= (w_we[p] && (c_mode == c_wf)) ? w_merge : w_old[p];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic              r_v1, r_u1;
      logic [DATA_W-1:0] r_d1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v1 <= 1'b0;
          r_u1 <= 1'b0;
          r_d1 <= '0;
        end else begin
          r_v1 <= r_v0;
          r_u1 <= r_u0;
          r_d1 <= r_d0;
        end
      end
      assign w_v1 = r_v1;
      assign w_u1 = r_u1;
      assign w_d1 = r_d1;
    end else begin : g_noreg
      assign w_v1 = r_v0;
      assign w_u1 = r_u0;
      assign w_d1 = r_d0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vo <= 1'b0;
        r_do <= '0;
      end else begin
        r_vo <= w_v1;
        if (w_u1) r_do <= w_d1;
      end
    end

    assign w_out[p] = r_do;
    assign w_vld[p] = r_vo;
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_gen.sv
`default_nettype none
// Bench for dpram_gen: three instances (write-first/lat1, read-first/lat2,
// no-change/lat1) share stimulus and are compared against a word-level model.
module tb_dpram_gen;

  localparam logic [15:0] INIT = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  aa, ba;
  logic [15:0] ai, bi;
  logic        acs, awe, bcs, bwe;
  logic [1:0]  abe, bbe;
  logic [15:0] ao_w [3];
  logic [15:0] bo_w [3];
  logic        aov_w [3];
  logic        bov_w [3];
  logic        busy_w [3];

  always #5 clk = ~clk;

  dpram_gen #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .WMODE_A("WRITE_FIRST"),
              .WMODE_B("WRITE_FIRST"), .INIT_VAL(INIT)) u_wf (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_w[0]),
    .aa(aa), .ai(ai), .acs(acs), .awe(awe), .abe(abe), .ao(ao_w[0]), .aov(aov_w[0]),
    .ba(ba), .bi(bi), .bcs(bcs), .bwe(bwe), .bbe(bbe), .bo(bo_w[0]), .bov(bov_w[0]));

  dpram_gen #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .WMODE_A("READ_FIRST"),
              .WMODE_B("READ_FIRST"), .INIT_VAL(INIT)) u_rf (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_w[1]),
    .aa(aa), .ai(ai), .acs(acs), .awe(awe), .abe(abe), .ao(ao_w[1]), .aov(aov_w[1]),
    .ba(ba), .bi(bi), .bcs(bcs), .bwe(bwe), .bbe(bbe), .bo(bo_w[1]), .bov(bov_w[1]));

  dpram_gen #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .WMODE_A("NO_CHANGE"),
              .WMODE_B("NO_CHANGE"), .INIT_VAL(INIT)) u_nc (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_w[2]),
    .aa(aa), .ai(ai), .acs(acs), .awe(awe), .abe(abe), .ao(ao_w[2]), .aov(aov_w[2]),
    .ba(ba), .bi(bi), .bcs(bcs), .bwe(bwe), .bbe(bbe), .bo(bo_w[2]), .bov(bov_w[2]));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int clr_left;
  int n;
  int modes [3] = '{0, 1, 2};
  int lat   [3] = '{0, 1, 0};
  logic [15:0] mem_m [16];
  logic        sv [3][2][4];
  logic        su [3][2][4];
  logic [15:0] sd [3][2][4];
  logic        exp_v [3][2];
  logic [15:0] exp_d [3][2];

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] nw,
                                        input logic [1:0] be);
    merge = o;
    if (be[0]) merge[7:0]  = nw[7:0];
    if (be[1]) merge[15:8] = nw[15:8];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = 16;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        exp_v[k][p] = 1'b0;
        exp_d[k][p] = '0;
        for (int s = 0; s < 4; s++) sv[k][p][s] = 1'b0;
      end
  endtask

  task automatic sched(input int k, input int p, input logic acc, input logic we,
                       input logic [15:0] old, input logic [15:0] mrg);
    int s;
    if (!acc) return;
    s = (edge_n + 1 + lat[k]) % 4;
    sv[k][p][s] = 1'b1;
    su[k][p][s] = !(we && modes[k] == 2);
    sd[k][p][s] = (we && modes[k] == 0) ? mrg : old;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy_i%0d", k), {15'b0, busy_w[k]}, {15'b0, (clr_left > 0)});
      chk($sformatf("aov_i%0d", k), {15'b0, aov_w[k]}, {15'b0, exp_v[k][0]});
      chk($sformatf("bov_i%0d", k), {15'b0, bov_w[k]}, {15'b0, exp_v[k][1]});
      chk($sformatf("ao_i%0d", k), ao_w[k], exp_d[k][0]);
      chk($sformatf("bo_i%0d", k), bo_w[k], exp_d[k][1]);
    end
  endtask

  task automatic cyc();
    logic [15:0] oa, ob;
    logic        ka, kb, bp;
    int          s;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_reset();
    end else begin
      bp = (clr_left > 0);
      oa = mem_m[aa];
      ob = mem_m[ba];
      ka = acs && !bp;
      kb = bcs && !bp;
      for (int k = 0; k < 3; k++) begin
        sched(k, 0, ka, awe, oa, merge(oa, ai, abe));
        sched(k, 1, kb, bwe, ob, merge(ob, bi, bbe));
      end
      if (kb && bwe) mem_m[ba] = merge(mem_m[ba], bi, bbe);
      if (ka && awe) mem_m[aa] = merge(mem_m[aa], ai, abe);
      if (bp) mem_m[16 - clr_left] = INIT;
      if (clr) clr_left = 16;
      else if (bp) clr_left--;
    end
    #1;
    s = edge_n % 4;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        exp_v[k][p] = sv[k][p][s];
        if (sv[k][p][s] && su[k][p][s]) exp_d[k][p] = sd[k][p][s];
        sv[k][p][s] = 1'b0;
      end
    check_all();
  endtask

  task automatic set_a(input logic cs, input logic we, input logic [3:0] ad,
                       input logic [15:0] d, input logic [1:0] be);
    acs = cs; awe = we; aa = ad; ai = d; abe = be;
  endtask

  task automatic set_b(input logic cs, input logic we, input logic [3:0] ad,
                       input logic [15:0] d, input logic [1:0] be);
    bcs = cs; bwe = we; ba = ad; bi = d; bbe = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    set_b(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
  endtask

  task automatic rand_drive(input bit allow_clr);
    set_a(1'($urandom_range(9) < 7), 1'($urandom_range(1)), 4'($urandom_range(15)),
          16'($urandom), 2'($urandom_range(3)));
    set_b(1'($urandom_range(9) < 7), 1'($urandom_range(1)), 4'($urandom_range(15)),
          16'($urandom), 2'($urandom_range(3)));
    if ($urandom_range(3) == 0) ba = aa;
    clr = allow_clr && ($urandom_range(99) == 0);
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;

    // Power-up clear: user traffic during BUSY must be ignored.
    n = 0;
    while (busy_w[0] && n < 40) begin
      n++;
      rand_drive(1'b0);
      cyc();
    end
    chk("t1_busy_len", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'(i), 16'h0, 2'b00);
      set_b(1'b1, 1'b0, 4'(15 - i), 16'h0, 2'b00);
      cyc();
    end
    idle();
    cyc(); cyc();
    chk("t1_ao_init", ao_w[0], INIT);
    chk("t1_bo_init", bo_w[1], INIT);

    // Single-lane write then cross-port read.
    set_a(1'b1, 1'b1, 4'd3, 16'h1234, 2'b01); cyc();
    idle(); set_b(1'b1, 1'b0, 4'd3, 16'h0, 2'b00); cyc();
    idle(); cyc();
    chk("t2_bo_lane", bo_w[0], 16'hA534);

    // Dual write collisions.
    set_a(1'b1, 1'b1, 4'd5, 16'hAAAA, 2'b11);
    set_b(1'b1, 1'b1, 4'd5, 16'hBBBB, 2'b11); cyc();
    idle(); set_a(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); cyc();
    idle(); cyc();
    chk("t3_a_wins", ao_w[0], 16'hAAAA);
    set_a(1'b1, 1'b1, 4'd5, 16'hAAAA, 2'b01);
    set_b(1'b1, 1'b1, 4'd5, 16'hBBBB, 2'b10); cyc();
    idle(); set_b(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); cyc();
    idle(); cyc();
    chk("t3_split", bo_w[0], 16'hBBAA);

    // Write vs read collision and write-mode outputs; read-first also has latency 2.
    set_a(1'b1, 1'b1, 4'd7, 16'h0F0F, 2'b11); cyc();
    idle(); cyc();
    set_a(1'b1, 1'b1, 4'd7, 16'h5555, 2'b11);
    set_b(1'b1, 1'b0, 4'd7, 16'h0, 2'b00); cyc();
    idle(); cyc();
    chk("t4_wf_ao", ao_w[0], 16'h5555);
    chk("t4_wf_bo_old", bo_w[0], 16'h0F0F);
    chk("t4_nc_hold", ao_w[2], 16'hAAAA);
    chk("t4_nc_aov", {15'b0, aov_w[2]}, 16'd1);
    chk("t5_lat2_early", {15'b0, aov_w[1]}, 16'd0);
    cyc();
    chk("t5_lat2_aov", {15'b0, aov_w[1]}, 16'd1);
    chk("t4_rf_ao", ao_w[1], 16'h0F0F);
    chk("t4_rf_bo", bo_w[1], 16'h0F0F);

    // Back-to-back random traffic, streaming reads and writes on both ports.
    repeat (250) begin
      rand_drive(1'b0);
      cyc();
    end

    // Clear request, then reset in the middle of the clear sweep.
    idle(); clr = 1'b1; cyc();
    clr = 1'b0;
    repeat (5) begin
      rand_drive(1'b0);
      cyc();
    end
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_ao_rst", ao_w[0], 16'h0);
    chk("t6_aov_rst", {15'b0, aov_w[1]}, 16'd0);
    chk("t6_busy_rst", {15'b0, busy_w[2]}, 16'd1);
    check_all();
    repeat (2) cyc();
    rst = 1'b0;
    n = 0;
    while (busy_w[0] && n < 40) begin
      n++;
      rand_drive(1'b0);
      cyc();
    end
    chk("t6_busy_len", 16'(n), 16'd16);

    repeat (300) begin
      rand_drive(1'b1);
      cyc();
    end
    clr = 1'b0;
    idle();
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
